// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared constants and types for the Mandelbrot escape-time iterator
// Purpose: default fixed-point format, escape threshold, count width and FSM state type.
// Ports: none (package).
package mandel_pkg;

    localparam int W_DEF        = 32;
    localparam int FRAC_DEF     = 28;
    localparam int MAX_ITER_DEF = 255;
    localparam int CNT_W        = 24;

    // 4.0 expressed in the 2W+1-bit magnitude domain (products carry 2*FRAC fraction bits)
    localparam logic [2*W_DEF:0] FOUR_DEF = {{(2*W_DEF-2){1'b0}}, 3'd4} << (2*FRAC_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

endpackage

// File: rtl/mandel_iter_if.sv
// rtl/mandel_iter_if.sv - pixel request / result bundle between a lane driver and mandel_iter
// Purpose: groups start/c inputs and busy/hit/count/done/in_set results.
// Ports: master drives start, c_re, c_im and observes results; slave is the iterator side.
interface mandel_iter_if
    import mandel_pkg::*;
#(
    parameter int W = W_DEF
);

    logic                 start;
    logic signed [W-1:0]  c_re;
    logic signed [W-1:0]  c_im;
    logic                 busy;
    logic                 hit;
    logic [CNT_W-1:0]     count;
    logic                 done;
    logic                 in_set;

    modport master (
        output start, c_re, c_im,
        input  busy, hit, count, done, in_set
    );

    modport slave (
        input  start, c_re, c_im,
        output busy, hit, count, done, in_set
    );

endinterface

// File: rtl/fx_mul.sv
// rtl/fx_mul.sv - signed W x W -> 2W combinational multiplier
// Purpose: full-precision product used for zr^2, zi^2 and zr*zi.
// Ports: a_i, b_i signed W-bit operands; p_o signed 2W-bit product.
module fx_mul #(
    parameter int W = 32
) (
    input  logic signed [W-1:0]   a_i,
    input  logic signed [W-1:0]   b_i,
    output logic signed [2*W-1:0] p_o
);

    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;

    assign a_ext = {{W{a_i[W-1]}}, a_i};
    assign b_ext = {{W{b_i[W-1]}}, b_i};
    assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/mandel_iter.sv
// rtl/mandel_iter.sv - escape-time iterator for one Mandelbrot pixel
// Purpose: iterates z <- z^2 + c from z=0, one iteration per clock, and reports the
//          first index whose |z|^2 exceeds 4.0 (or MAX_ITER when none does).
// Ports: aclk clock; rst async active-high reset;
//        bus (slave): start, c_re, c_im in; busy, hit, count, done, in_set out.
module mandel_iter
    import mandel_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic          aclk,
    input  logic          rst,
    mandel_iter_if.slave  bus
);

    localparam logic signed [2*W:0]   FOUR  = {{(2*W-2){1'b0}}, 3'd4} << (2*FRAC);
    localparam logic [CNT_W-1:0]      MAX_N = CNT_W'(MAX_ITER);

    state_t                state_q, state_d;
    logic                  first_q, first_d;
    logic signed [W-1:0]   cr_q, cr_d;
    logic signed [W-1:0]   ci_q, ci_d;
    logic signed [W-1:0]   zr_q, zr_d;
    logic signed [W-1:0]   zi_q, zi_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic                  hit_q, hit_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  in_set_q, in_set_d;

    logic signed [2*W-1:0] rr, ii, ri;
    logic signed [2*W:0]   mag, diff;
    logic signed [W-1:0]   zr_next, zi_next;
    logic                  escape;
    logic                  unused_bits;

    fx_mul #(.W(W)) u_mul_rr (.a_i(zr_q), .b_i(zr_q), .p_o(rr));
    fx_mul #(.W(W)) u_mul_ii (.a_i(zi_q), .b_i(zi_q), .p_o(ii));
    fx_mul #(.W(W)) u_mul_ri (.a_i(zr_q), .b_i(zi_q), .p_o(ri));

    assign mag    = {rr[2*W-1], rr} + {ii[2*W-1], ii};
    assign diff   = {rr[2*W-1], rr} - {ii[2*W-1], ii};
    // strict compare: |z|^2 == 4.0 stays inside
    assign escape = mag > FOUR;

    // Truncating rescale back to Q(W-FRAC).FRAC; taking ri one bit lower doubles it
    assign zr_next = diff[W+FRAC-1:FRAC] + cr_q;
    assign zi_next = ri[W+FRAC-2:FRAC-1] + ci_q;

    assign unused_bits = ^{diff[2*W:W+FRAC], diff[FRAC-1:0],
                           ri[2*W-1:W+FRAC-1], ri[FRAC-2:0]};

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        cr_d     = cr_q;
        ci_d     = ci_q;
        zr_d     = zr_q;
        zi_d     = zi_q;
        n_d      = n_q;
        hit_d    = 1'b0;
        done_d   = 1'b0;
        count_d  = count_q;
        in_set_d = in_set_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = ITER;
                    first_d  = 1'b1;
                    cr_d     = bus.c_re;
                    ci_d     = bus.c_im;
                    zr_d     = '0;
                    zi_d     = '0;
                    n_d      = '0;
                    count_d  = '0;
                    in_set_d = 1'b0;
                end
            end
            ITER: begin
                if (first_q) begin
                    // Settle cycle after accept: z(0) is evaluated next cycle,
                    // giving an escape latency of n+2 from the start edge.
                    first_d = 1'b0;
                end else if (escape) begin
                    state_d  = IDLE;
                    hit_d    = 1'b1;
                    done_d   = 1'b1;
                    count_d  = n_q;
                    in_set_d = 1'b0;
                end else if (n_q == MAX_N) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    count_d  = MAX_N;
                    in_set_d = 1'b1;
                end else begin
                    zr_d = zr_next;
                    zi_d = zi_next;
                    n_d  = n_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            first_q  <= 1'b0;
            cr_q     <= '0;
            ci_q     <= '0;
            zr_q     <= '0;
            zi_q     <= '0;
            n_q      <= '0;
            hit_q    <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            in_set_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            cr_q     <= cr_d;
            ci_q     <= ci_d;
            zr_q     <= zr_d;
            zi_q     <= zi_d;
            n_q      <= n_d;
            hit_q    <= hit_d;
            done_q   <= done_d;
            count_q  <= count_d;
            in_set_q <= in_set_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.hit    = hit_q;
    assign bus.done   = done_q;
    assign bus.count  = count_q;
    assign bus.in_set = in_set_q;

endmodule

// File: tb/tb_mandel_iter.sv
// tb/tb_mandel_iter.sv - scoreboard bench for mandel_iter
module tb_mandel_iter;
    import mandel_pkg::*;

    typedef struct {
        logic        hit;
        logic [23:0] count;
        logic        in_set;
        int          due;
        string       name;
    } exp_t;

    localparam logic signed [31:0] HALF  = 32'sh0800_0000;
    localparam logic signed [31:0] THREE = 32'sh3000_0000;
    localparam logic signed [31:0] NEG2  = 32'shE000_0000;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;
    int   start_cyc = 0;
    exp_t sb[$];

    mandel_iter_if #(.W(32)) bus();

    mandel_iter #(.W(32), .FRAC(28), .MAX_ITER(255)) dut (
        .aclk (aclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns one negedge later with start dropped.
    task automatic issue(input logic signed [31:0] re, input logic signed [31:0] im);
        bus.start = 1'b1;
        bus.c_re  = re;
        bus.c_im  = im;
        start_cyc = cyc + 1;
        @(negedge aclk);
        bus.start = 1'b0;
    endtask

    task automatic expect_px(input string name, input logic h, input int cnt,
                             input logic s, input int lat);
        exp_t e;
        e.hit = h; e.count = 24'(cnt); e.in_set = s; e.due = start_cyc + lat; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (sb.size() == 0) break;
            @(negedge aclk);
        end
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: every done pulse is matched against the head of the scoreboard
    always @(negedge aclk) begin
        if (!rst) begin
            if (bus.hit && !bus.done) check("hit_without_done", 32'(bus.done), 32'd1);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_hit"},    32'(bus.hit),    32'(e.hit));
                    check({e.name, "_count"},  32'(bus.count),  32'(e.count));
                    check({e.name, "_in_set"}, 32'(bus.in_set), 32'(e.in_set));
                    check({e.name, "_cycle"},  32'(cyc),        32'(e.due));
                end
            end
        end
    end

    initial begin
        int sc;
        int busy_cycles;
        bus.start = 1'b0;
        bus.c_re  = '0;
        bus.c_im  = '0;

        // reset state
        repeat (2) @(negedge aclk);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_hit",    32'(bus.hit),    32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_count",  32'(bus.count),  32'd0);
        check("rst_in_set", 32'(bus.in_set), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge aclk);

        // |c| > 2 escapes at n=1
        issue(THREE, '0);
        expect_px("c3", 1'b1, 1, 1'b0, 3);
        drain(20);
        @(negedge aclk);

        // c=0.5 escapes at n=5; start at +2 ignored; back-to-back start in done cycle
        issue(HALF, '0);
        sc = start_cyc;
        expect_px("c05", 1'b1, 5, 1'b0, 7);
        bus.start = 1'b1;          // sampled at E2 while busy
        bus.c_re  = THREE;
        @(negedge aclk);
        bus.start = 1'b0;
        while (cyc < sc + 7) @(negedge aclk);
        check("done_cycle_busy", 32'(bus.busy), 32'd0);
        issue(THREE, '0);
        expect_px("b2b_c3", 1'b1, 1, 1'b0, 3);
        drain(40);
        @(negedge aclk);

        // c=-2: |z|^2 sits exactly at 4.0, never escapes
        issue(NEG2, '0);
        expect_px("cm2", 1'b0, 255, 1'b1, 257);
        drain(300);
        @(negedge aclk);

        // c=0: never escapes; busy for 257 cycles
        issue('0, '0);
        expect_px("c0", 1'b0, 255, 1'b1, 257);
        busy_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus.busy) busy_cycles++;
            else if (busy_cycles > 0) break;
            @(negedge aclk);
        end
        check("c0_busy_cycles", 32'(busy_cycles), 32'd257);
        drain(20);
        @(negedge aclk);

        // reset mid-ITER at n=3 for c=0.5
        issue(HALF, '0);
        sc = start_cyc;
        while (cyc < sc + 4) @(negedge aclk);
        rst = 1'b1;
        #1;
        check("midrst_busy",   32'(bus.busy),   32'd0);
        check("midrst_hit",    32'(bus.hit),    32'd0);
        check("midrst_done",   32'(bus.done),   32'd0);
        check("midrst_count",  32'(bus.count),  32'd0);
        check("midrst_in_set", 32'(bus.in_set), 32'd0);
        repeat (2) @(negedge aclk);
        rst = 1'b0;
        repeat (20) @(negedge aclk);
        check("midrst_idle_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
